// File: rtl/reg_file.sv
// rtl/reg_file.sv - 32x32 register file, two combinational read ports, one write port
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module reg_file (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  input  logic [4:0]  rd_addr,
  input  logic [31:0] rd_data,
  input  logic        reg_write,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data
);

  logic [31:0] regs [32];

  // Entry 0 is cleared by reset and never written, so it stays zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (reg_write && (rd_addr != 5'd0)) begin
      regs[rd_addr] <= rd_data;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic wr_fwd;
  assign wr_fwd = reg_write && rst && (rd_addr != 5'd0);

  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != 5'd0)
      rs1_data = (wr_fwd && (rs1_addr == rd_addr)) ? rd_data : regs[rs1_addr];
    if (rs2_addr != 5'd0)
      rs2_data = (wr_fwd && (rs2_addr == rd_addr)) ? rd_data : regs[rs2_addr];
  end
`else
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (rs1_addr != 5'd0) rs1_data = regs[rs1_addr];
    if (rs2_addr != 5'd0) rs2_data = regs[rs2_addr];
  end
`endif

endmodule

// File: tb/tb_reg_file.sv
// tb/tb_reg_file.sv - randomized self-checking bench for reg_file against an array model
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        reg_write;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  int total = 0;
  int bad   = 0;
  logic [31:0] mdl [32];

  reg_file dut (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .reg_write(reg_write),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (!rst) return 32'h0;
`ifdef REGFILE_BYPASS_EN
    if (reg_write && rd_addr != 5'd0 && a == rd_addr) return rd_data;
`endif
    return mdl[a];
  endfunction

  task automatic chk_ports(input string tag);
    check({tag, "_rs1"}, rs1_data, exp_rd(rs1_addr));
    check({tag, "_rs2"}, rs2_data, exp_rd(rs2_addr));
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
  endtask

  // Advance one clock edge; the model commits what the DUT saw at that edge.
  task automatic cycle();
    @(posedge clk);
    if (reg_write && rd_addr != 5'd0 && rst) mdl[rd_addr] = rd_data;
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    rd_addr = a; rd_data = d; reg_write = 1'b1;
    cycle();
    reg_write = 1'b0;
  endtask

  initial begin
    rst = 1'b0; reg_write = 1'b0; rd_addr = '0; rd_data = '0;
    rs1_addr = 5'd5; rs2_addr = 5'd31;
    model_clear();
    #2;
    chk_ports("reset_hold");
    cycle();
    chk_ports("reset_after_edge");

    @(negedge clk);
    rst = 1'b1;
    #1;

    // Async reset clears storage mid-cycle
    wr(5'd5, 32'hDEADBEEF);
    rs1_addr = 5'd5;
    #1;
    check("x5_written", rs1_data, 32'hDEADBEEF);
    rst = 1'b0;
    model_clear();
    #1;
    check("reset_immediate", rs1_data, 32'h0);
    for (int i = 0; i < 32; i++) begin
      rs1_addr = 5'(i); rs2_addr = 5'(31 - i);
      #1;
      chk_ports($sformatf("reset_all_%0d", i));
    end

    // A write in progress when reset asserts is aborted
    @(negedge clk);
    rst = 1'b1;
    rd_addr = 5'd12; rd_data = 32'hCAFEF00D; reg_write = 1'b1;
    #2;
    rst = 1'b0;
    cycle();
    @(negedge clk);
    reg_write = 1'b0;
    rst = 1'b1;
    rs1_addr = 5'd12;
    #1;
    check("abort_write", rs1_data, 32'h0);

    // First edge with rst high honors the write
    wr(5'd13, 32'h0BADCAFE);
    rs1_addr = 5'd13;
    #1;
    check("first_edge_write", rs1_data, 32'h0BADCAFE);

    // x0 stays zero
    rs1_addr = 5'd0; rd_addr = 5'd0; rd_data = 32'hFFFFFFFF; reg_write = 1'b1;
    #1;
    check("x0_same_cycle", rs1_data, 32'h0);
    cycle();
    reg_write = 1'b0;
    check("x0_after_edge", rs1_data, 32'h0);

    // Write then read on both ports, neighbours untouched
    wr(5'd6, 32'h66666666);
    wr(5'd8, 32'h88888888);
    wr(5'd7, 32'h12345678);
    rs1_addr = 5'd7; rs2_addr = 5'd7;
    #1;
    check("x7_rs1", rs1_data, 32'h12345678);
    check("x7_rs2", rs2_data, 32'h12345678);
    rs1_addr = 5'd6; rs2_addr = 5'd8;
    #1;
    check("x6_unchanged", rs1_data, 32'h66666666);
    check("x8_unchanged", rs2_data, 32'h88888888);

    // Same-cycle read of the register being written
    wr(5'd3, 32'hA5A5A5A5);
    rs2_addr = 5'd3; rd_addr = 5'd3; rd_data = 32'h5A5A5A5A; reg_write = 1'b1;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("same_cycle_before", rs2_data, 32'h5A5A5A5A);
`else
    check("same_cycle_before", rs2_data, 32'hA5A5A5A5);
`endif
    cycle();
    reg_write = 1'b0;
    check("same_cycle_after", rs2_data, 32'h5A5A5A5A);

    // Hold with reg_write low
    wr(5'd9, 32'h00000042);
    rd_addr = 5'd9; rd_data = 32'h1; reg_write = 1'b0; rs1_addr = 5'd9;
    for (int i = 0; i < 10; i++) cycle();
    check("hold_x9", rs1_data, 32'h00000042);

    // Sweep all entries
    for (int i = 1; i < 32; i++) wr(5'(i), i * 32'h01010101);
    for (int i = 0; i < 32; i += 2) begin
      rs1_addr = 5'(i); rs2_addr = 5'(i + 1);
      #1;
      check($sformatf("sweep_rs1_%0d", i), rs1_data, i * 32'h01010101);
      check($sformatf("sweep_rs2_%0d", i + 1), rs2_data, (i + 1) * 32'h01010101);
    end
    rs1_addr = 5'd31;
    #1;
    check("sweep_x31", rs1_data, 32'h1F1F1F1F);

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      reg_write = 1'($urandom_range(0, 1));
      rd_addr   = 5'($urandom_range(0, 31));
      rd_data   = $urandom;
      rs1_addr  = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31));
      rs2_addr  = ($urandom_range(0, 3) == 0) ? rd_addr : 5'($urandom_range(0, 31));
      #1;
      chk_ports($sformatf("rand_pre_%0d", n));
      cycle();
      reg_write = 1'b0;
      #1;
      chk_ports($sformatf("rand_post_%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 reg_file SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-002 clk  input  1  rising-edge clock for all storage.
REQ-003 rst  input  1  asynchronous active-low reset; 0 clears all storage.
REQ-004 rs1_addr  input  5  read port 1 register index.
REQ-005 rs2_addr  input  5  read port 2 register index.
REQ-006 rd_addr  input  5  write port register index.
REQ-007 rd_data  input  32  write data.
REQ-008 reg_write  input  1  write enable, sampled on the rising clk edge.
REQ-009 rs1_data  output  32  read port 1 data (combinational).
REQ-010 rs2_data  output  32  read port 2 data (combinational).

Function
REQ-011 Storage SHALL be 32 entries x 32 bits, x0..x31.
REQ-012 Writes SHALL occur on the rising clk edge when reg_write=1, rd_addr!=0 and rst=1; the entry SHALL take rd_data.
REQ-013 Entries not addressed, or any entry when reg_write=0, SHALL hold their value.
REQ-014 Writes to rd_addr=0 SHALL be discarded; x0 SHALL always read 32'h00000000.
REQ-015 Reads SHALL be combinational with zero-cycle latency: rsN_data = entry[rsN_addr].
REQ-016 Both read ports SHALL operate independently; rs1_addr=rs2_addr SHALL return identical data on both ports.
REQ-017 Without bypass, a read of the register written in the same cycle SHALL return the old value until after the clk edge.
REQ-018 Outputs SHALL never be X after reset for any valid 5-bit address.

Reset
REQ-019 While rst=0, all 32 entries SHALL be 0, so rs1_data and rs2_data SHALL be 0, regardless of clk.
REQ-020 Assertion of rst SHALL take effect immediately, without waiting for a clk edge, and SHALL abort a write in progress.
REQ-021 A write SHALL be honored on the first rising clk edge at which rst=1.

Configuration
REQ-022 Macro REGFILE_BYPASS_EN SHALL control write-to-read forwarding.
REQ-023 With REGFILE_BYPASS_EN defined, if reg_write=1, rd_addr!=0, rst=1 and rsN_addr=rd_addr, then rsN_data SHALL equal rd_data in the same cycle. This applies to each port independently.
REQ-024 With REGFILE_BYPASS_EN defined, bypass SHALL never apply to rd_addr=0, and SHALL be suppressed while rst=0.
REQ-025 Without REGFILE_BYPASS_EN, behaviour SHALL follow REQ-017, and no forwarding logic SHALL be present.

Verification
REQ-026 Reset: drive rst=0 mid-cycle after writing x5=32'hDEADBEEF. Required response: rs1_addr=5 reads 0 immediately, and all 32 entries read 0.
REQ-027 Write/read: write x7=32'h12345678, then on the next cycle set rs1_addr=7 and rs2_addr=7. Required response: both ports read 32'h12345678, and x6 and x8 are unchanged.
REQ-028 x0: write rd_addr=0 with rd_data=32'hFFFFFFFF and reg_write=1. Required response: rs1_addr=0 reads 0 in the same cycle and after the edge, under both configurations.
REQ-029 Same-cycle read of a write: x3 holds 32'hA5A5A5A5; write x3=32'h5A5A5A5A with rs2_addr=3. Required response before the edge: 32'hA5A5A5A5 without the macro, 32'h5A5A5A5A with REGFILE_BYPASS_EN. Required response after the edge: 32'h5A5A5A5A under both configurations.
REQ-030 Hold: reg_write=0 with rd_addr=9 and rd_data=32'h1 for 10 cycles. Required response: x9 retains its prior value of 32'h00000042.
REQ-031 Sweep: write x[i]=i*32'h01010101 for i=1..31, then read all entries pairwise on rs1 and rs2. Required response: every value matches, and x31 reads 32'h1F1F1F1F.
